mips_mc_ctrl: RTL and testbench

Multicycle control FSM for the word-addressed MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback, and runs the single shared memory port through a req/ack handshake. It also drives the PC register's write enable and its `{PCSrc,Branch}` next-PC select. It sits between the instruction register's opcode field and every datapath control point: PC, IR, register file, ALU muxes and memory.

---
 rtl/mips_mc_ctrl_pkg.sv | 51 +++++
 rtl/mips_mc_ctrl_if.sv | 35 +++
 rtl/mips_mc_ctrl_opdecode.sv | 29 ++
 rtl/mips_mc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Optional feature macro: MIPS_BNE_EN (bne decode).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Next-PC select, {PCSrc,Branch}
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    // Instruction class, one-hot (all zero = unsupported)
    typedef struct packed {
        logic rtype;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
    } iclass_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle FSM (master) and the
// datapath/memory side (slave).
interface mips_mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       ir_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       pc_en;
    logic       PCSrc;
    logic       Branch;
    logic       illegal;
    logic       mem_err;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, mem_sel, ir_we, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, pc_en, PCSrc, Branch,
               illegal, mem_err
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, mem_sel, ir_we, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, pc_en, PCSrc, Branch,
               illegal, mem_err
    );
endinterface

// File: rtl/mips_mc_ctrl_opdecode.sv
// Opcode -> instruction class one-hot plus unsupported flag.
// bne is only recognised when MIPS_BNE_EN is defined.
module mips_opdecode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output iclass_t    o_cls,
    output logic       o_illegal
);

    // Class lookup; anything not listed falls out as illegal
    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_RTYPE: o_cls.rtype = 1'b1;
            OP_ADDI:  o_cls.addi  = 1'b1;
            OP_LW:    o_cls.lw    = 1'b1;
            OP_SW:    o_cls.sw    = 1'b1;
            OP_BEQ:   o_cls.beq   = 1'b1;
`ifdef MIPS_BNE_EN
            OP_BNE:   o_cls.bne   = 1'b1;
`endif
            OP_J:     o_cls.j     = 1'b1;
            default:  o_cls       = '0;
        endcase
        o_illegal = (o_cls == '0);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback
// sequencing, shared memory port handshake with ack watchdog, and
// PC write enable / next-PC select.
// Optional feature macro: MIPS_BNE_EN (bne decoded as inverted-zero branch).
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus
);

    localparam bit          WD_EN    = (ACK_TIMEOUT != 0);
    localparam logic [15:0] WD_LIMIT = 16'(ACK_TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wd_cnt;
    logic        r_illegal;
    logic        r_mem_err;
    logic        w_req;
    logic        w_timeout;
    logic [1:0]  w_pc_sel;
    iclass_t     w_cls;
    logic        w_dec_illegal;

    // IR holds the opcode from DECODE onward, so the class is reused
    // later (MEM_ADDR lw/sw split, WB_ALU rd/rt, BRANCH polarity).
    mips_opdecode u_dec (
        .i_opcode  (bus.opcode),
        .o_cls     (w_cls),
        .o_illegal (w_dec_illegal)
    );

    assign w_req = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                   (r_state == S_MEM_WR);

    // Limit is hit on the request cycle that would make the count reach
    // ACK_TIMEOUT; a same-cycle ack takes priority.
    assign w_timeout = WD_EN && w_req && !bus.mem_ack &&
                       ((r_wd_cnt + 16'd1) == WD_LIMIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Watchdog: counts unacked request cycles, zero otherwise, so every
    // request state is entered with a clear count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_wd_cnt <= '0;
        else if (w_req && !bus.mem_ack) r_wd_cnt <= r_wd_cnt + 16'd1;
        else                          r_wd_cnt <= '0;
    end

    // Sticky trap causes, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state == S_DECODE && w_dec_illegal) r_illegal <= 1'b1;
            if (w_timeout)                            r_mem_err <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                if (w_cls.rtype)                 w_next = S_EXEC_R;
                else if (w_cls.addi)             w_next = S_EXEC_I;
                else if (w_cls.lw || w_cls.sw)   w_next = S_MEM_ADDR;
                else if (w_cls.beq || w_cls.bne) w_next = S_BRANCH;
                else if (w_cls.j)                w_next = S_JUMP;
                else                             w_next = S_TRAP;
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = w_cls.sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ack)    w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ack)    w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_IDLE;
        endcase
    end

    // Control outputs from state, plus the ir_we and store pc_en Mealy terms
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_sel    = 1'b0;
        bus.ir_we      = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.pc_en      = 1'b0;
        w_pc_sel       = PC_INC;
        case (r_state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ack;
            end
            S_EXEC_R: bus.alu_op = ALU_FUNCT;
            S_EXEC_I, S_MEM_ADDR: begin
                bus.alu_op    = ALU_ADD;
                bus.alu_src_b = 1'b1;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.mem_sel = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.mem_sel = 1'b1;
                bus.pc_en   = bus.mem_ack;
            end
            S_WB_ALU: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = w_cls.rtype;
                bus.pc_en   = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.pc_en      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_op = ALU_SUB;
                bus.pc_en  = 1'b1;
                w_pc_sel   = {1'b0, bus.zero ^ w_cls.bne};
            end
            S_JUMP: begin
                bus.pc_en = 1'b1;
                w_pc_sel  = PC_JMP;
            end
            default: ;
        endcase
    end

    assign bus.PCSrc   = w_pc_sel[1];
    assign bus.Branch  = w_pc_sel[0];
    assign bus.illegal = r_illegal;
    assign bus.mem_err = r_mem_err;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: an instruction-level model expands
// each instruction (with chosen wait counts) into its expected per-cycle
// control vector; the DUT is stepped cycle by cycle against that plan.
module tb_mips_mc_ctrl;

    localparam int TMO = 4;

    localparam logic [5:0] O_R = 6'h00, O_ADDI = 6'h08, O_LW = 6'h23,
                           O_SW = 6'h2B, O_BEQ = 6'h04, O_BNE = 6'h05,
                           O_J = 6'h02;

    // Expected-vector bits
    localparam logic [14:0] B_REQ  = 15'h4000, B_WE   = 15'h2000,
                            B_SEL  = 15'h1000, B_IRWE = 15'h0800,
                            B_RWE  = 15'h0400, B_RDST = 15'h0200,
                            B_M2R  = 15'h0100, B_SRCB = 15'h0080,
                            A_FN   = 15'h0040, A_SUB  = 15'h0020,
                            B_PCEN = 15'h0010, P_JMP  = 15'h0008,
                            P_BR   = 15'h0004, B_ILL  = 15'h0002,
                            B_MERR = 15'h0001;

    typedef struct {
        logic [14:0] exp;
        logic        ack;
        logic [5:0]  op;
        logic        z;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   gidx = 0;
    cyc_t plan[$];

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.ACK_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_we, bus.reg_we,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op,
                bus.pc_en, bus.PCSrc, bus.Branch, bus.illegal, bus.mem_err};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] op);
        bit l;
        l = (op == O_R) || (op == O_ADDI) || (op == O_LW) || (op == O_SW) ||
            (op == O_BEQ) || (op == O_J);
`ifdef MIPS_BNE_EN
        l = l || (op == O_BNE);
`endif
        return l;
    endfunction

    task automatic check(input string tag, input logic [14:0] a, input logic [14:0] e);
        checks++;
        assert (a === e) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, a, e);
        end
    endtask

    task automatic push(input logic [14:0] e, input logic ack, input logic [5:0] op, input logic z);
        cyc_t c;
        c.exp = e; c.ack = ack; c.op = op; c.z = z;
        plan.push_back(c);
    endtask

    // Cycle with no request: ack is noise the controller must ignore
    task automatic push_nr(input logic [14:0] e, input logic [5:0] op);
        push(e, rb(), op, rb());
    endtask

    // Instruction fetch with w wait cycles (opcode not yet meaningful)
    task automatic add_fetch(input int w);
        for (int i = 0; i <= w; i++)
            push(B_REQ | ((i == w) ? B_IRWE : 15'h0), (i == w), ro(), rb());
    endtask

    // One complete instruction: fw fetch waits, dw data waits, bz = zero in branch cycle
    task automatic add_instr(input logic [5:0] op, input int fw, input int dw, input logic bz);
        logic tk;
        add_fetch(fw);
        push_nr(15'h0, op);
        case (op)
            O_R: begin
                push_nr(A_FN, op);
                push_nr(B_RWE | B_RDST | B_PCEN, op);
            end
            O_ADDI: begin
                push_nr(B_SRCB, op);
                push_nr(B_RWE | B_PCEN, op);
            end
            O_LW: begin
                push_nr(B_SRCB, op);
                for (int i = 0; i <= dw; i++) push(B_REQ | B_SEL, (i == dw), op, rb());
                push_nr(B_RWE | B_M2R | B_PCEN, op);
            end
            O_SW: begin
                push_nr(B_SRCB, op);
                for (int i = 0; i <= dw; i++)
                    push(B_REQ | B_WE | B_SEL | ((i == dw) ? B_PCEN : 15'h0), (i == dw), op, rb());
            end
            O_BEQ, O_BNE: begin
                tk = (op == O_BEQ) ? bz : !bz;
                push(A_SUB | B_PCEN | (tk ? P_BR : 15'h0), rb(), op, bz);
            end
            default: push_nr(B_PCEN | P_JMP, op); // j
        endcase
    endtask

    task automatic add_rand_instr();
        logic [5:0] ops[7];
        int n;
        ops = '{O_R, O_ADDI, O_LW, O_SW, O_BEQ, O_J, O_BNE};
`ifdef MIPS_BNE_EN
        n = 7;
`else
        n = 6;
`endif
        add_instr(ops[$urandom_range(0, n - 1)], $urandom_range(0, TMO - 1),
                  $urandom_range(0, TMO - 1), rb());
    endtask

    task automatic add_trap(input int n, input logic [14:0] e);
        for (int i = 0; i < n; i++) push_nr(e, ro());
    endtask

    task automatic add_illegal(input logic [5:0] op);
        add_fetch($urandom_range(0, TMO - 1));
        push_nr(15'h0, op);
        add_trap(5, B_ILL);
    endtask

    // kind 0: fetch never acked; 1: lw data never acked; 2: sw never acked
    task automatic add_timeout(input int kind);
        if (kind == 0) begin
            for (int i = 0; i < TMO; i++) push(B_REQ, 1'b0, ro(), rb());
        end else begin
            add_fetch($urandom_range(0, TMO - 1));
            push_nr(15'h0, (kind == 1) ? O_LW : O_SW);
            push_nr(B_SRCB, (kind == 1) ? O_LW : O_SW);
            for (int i = 0; i < TMO; i++)
                push((kind == 1) ? (B_REQ | B_SEL) : (B_REQ | B_WE | B_SEL),
                     1'b0, (kind == 1) ? O_LW : O_SW, rb());
        end
        add_trap(5, B_MERR);
    endtask

    // Entered at posedge+1; plays up to maxn planned cycles, then drops the rest
    task automatic run_plan(input int maxn);
        cyc_t c;
        int n = 0;
        while (plan.size() > 0 && n < maxn) begin
            c = plan.pop_front();
            bus.mem_ack = c.ack;
            bus.opcode  = c.op;
            bus.zero    = c.z;
            @(negedge clk);
            check($sformatf("cyc%0d", gidx), obs(), c.exp);
            gidx++;
            n++;
            @(posedge clk);
            #1;
        end
        plan.delete();
    endtask

    // Asynchronous reset mid-cycle, then released at posedge+1 (IDLE cycle next)
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        bus.mem_ack = 1'b1;
        #1 check({tag, "_async"}, obs(), 15'h0);
        @(posedge clk);
        #1 check({tag, "_held"}, obs(), 15'h0);
        rst = 1'b0;
    endtask

    initial begin
        bus.opcode  = 6'h0;
        bus.zero    = 1'b0;
        bus.mem_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 check("reset", obs(), 15'h0);
        rst = 1'b0;

        // Directed instructions, boundary waits, random mix, then illegal trap
        push_nr(15'h0, ro());                 // IDLE
        add_instr(O_R,    0, 0, 1'b0);
        add_instr(O_LW,   2, 3, 1'b0);
        add_instr(O_BEQ,  0, 0, 1'b1);
        add_instr(O_BEQ,  0, 0, 1'b0);
        add_instr(O_J,    0, 0, 1'b0);
        add_instr(O_SW,   0, 0, 1'b0);
        add_instr(O_ADDI, 0, 0, 1'b0);
        add_instr(O_SW,   TMO - 1, TMO - 1, 1'b0); // ack on the limit cycle
        add_instr(O_LW,   TMO - 1, TMO - 1, 1'b0);
        for (int i = 0; i < 25; i++) add_rand_instr();
`ifdef MIPS_BNE_EN
        add_instr(O_BNE, 0, 0, 1'b0);
        add_instr(O_BNE, 1, 0, 1'b1);
        begin
            logic [5:0] bad;
            bad = ro();
            while (legal(bad)) bad = ro();
            add_illegal(bad);
        end
`else
        add_illegal(O_BNE);
`endif
        run_plan(100000);

        // Reset out of TRAP clears the sticky cause
        async_reset("rst_trap_ill");
        push_nr(15'h0, ro());
        for (int i = 0; i < 3; i++) add_rand_instr();
        add_timeout(0);
        run_plan(100000);

        async_reset("rst_trap_tmo0");
        push_nr(15'h0, ro());
        add_rand_instr();
        add_timeout($urandom_range(1, 2));
        run_plan(100000);

        async_reset("rst_trap_tmo");
        push_nr(15'h0, ro());
        add_timeout(3 - $urandom_range(1, 2));
        run_plan(100000);

        // Random illegal opcode
        async_reset("rst_trap_tmo2");
        begin
            logic [5:0] bad;
            bad = ro();
            while (legal(bad)) bad = ro();
            push_nr(15'h0, ro());
            add_illegal(bad);
        end
        run_plan(100000);

        // Reset in the middle of an instruction, then a clean restart
        async_reset("rst_trap_ill2");
        push_nr(15'h0, ro());
        add_instr(O_LW, 1, 2, 1'b0);
        run_plan(7);
        async_reset("rst_mid_instr");
        push_nr(15'h0, ro());
        add_instr(O_R, 0, 0, 1'b0);
        add_instr(O_J, 0, 0, 1'b0);
        run_plan(100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
